// File: rtl/spi_frame_rx.sv
// spi_frame_rx
//   SPI (mode 0) receive front end. Synchronizes raw SCLK/COPI/nCS into the
//   clk domain, shifts in 16-bit MSB-first frames and qualifies them.
//   Legal writes produce a one-cycle frame_valid strobe with address/data.
//   Reads are dropped silently. Malformed frames and unmapped addresses
//   produce a one-cycle frame_err strobe.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   sclk/copi/ncs: raw SPI pins (nCS active-low)
//   frame_valid  : accepted-write strobe
//   frame_addr   : address of last accepted frame (held)
//   frame_data   : data of last accepted frame (held)
//   frame_err    : rejected-frame strobe
//   busy         : synchronized nCS is low
module spi_frame_rx #(
  parameter int unsigned NUM_REGS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       frame_valid,
  output logic [6:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e state_q, state_d;

  // Bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge register).
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] ncs_sync_q,  ncs_sync_d;
  logic [1:0] copi_sync_q, copi_sync_d;

  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [6:0]  frame_addr_q, frame_addr_d;
  logic [7:0]  frame_data_q, frame_data_d;

  logic sclk_s2, sclk_s3, ncs_s2, ncs_s3, copi_s2;
  logic sclk_rise, ncs_fall, ncs_rise, ncs_fall_ok, addr_ok;

  assign sclk_s2 = sclk_sync_q[1];
  assign sclk_s3 = sclk_sync_q[2];
  assign ncs_s2  = ncs_sync_q[1];
  assign ncs_s3  = ncs_sync_q[2];
  assign copi_s2 = copi_sync_q[1];

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign ncs_fall  = ~ncs_s2 & ncs_s3;
  assign ncs_rise  = ncs_s2 & ~ncs_s3;

  // The nCS chain resets to 1, so a pin held low across reset release would
  // look like a falling edge once real samples arrive. Starting a frame is
  // therefore only allowed after the chain has been flushed with real samples
  // (settle count) and nCS has then been seen high at least once.
  assign ncs_fall_ok = ncs_fall & armed_q;

  assign addr_ok = ({25'd0, shreg_q[14:8]} < NUM_REGS);

  // Synchronizers and arming logic
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    ncs_sync_d  = {ncs_sync_q[1:0], ncs};
    copi_sync_d = {copi_sync_q[0], copi};
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d     = armed_q | ((settle_q == 2'd3) & ncs_s2);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall_ok) state_d = SHIFT;
      SHIFT:   if (ncs_rise)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    shreg_d       = shreg_q;
    bitcnt_d      = bitcnt_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    frame_addr_d  = frame_addr_q;
    frame_data_d  = frame_data_q;
    case (state_q)
      IDLE: begin
        if (ncs_fall_ok) begin
          shreg_d  = '0;
          bitcnt_d = '0;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          if (bitcnt_q != 5'd16) begin
            frame_err_d = 1'b1;
          end else if (shreg_q[15]) begin
            if (addr_ok) begin
              frame_valid_d = 1'b1;
              frame_addr_d  = shreg_q[14:8];
              frame_data_d  = shreg_q[7:0];
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end else if (sclk_rise && !ncs_s2) begin
          shreg_d = {shreg_q[14:0], copi_s2};
          if (bitcnt_q != 5'd17) bitcnt_d = bitcnt_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q   <= '0;
      copi_sync_q   <= '0;
      ncs_sync_q    <= '1;
      settle_q      <= '0;
      armed_q       <= 1'b0;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      copi_sync_q   <= copi_sync_d;
      ncs_sync_q    <= ncs_sync_d;
      settle_q      <= settle_d;
      armed_q       <= armed_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      frame_addr_q  <= frame_addr_d;
      frame_data_q  <= frame_data_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_addr  = frame_addr_q;
  assign frame_data  = frame_data_q;
  assign busy        = ~ncs_s2;

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx
//   Directed bench for spi_frame_rx: SCLK = clk/8, frames driven on the
//   falling clk edge, strobes counted by a monitor sampling on the falling edge.
module tb_spi_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       frame_valid;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_err;
  logic       busy;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // Monitor state (written only by the monitor process)
  int unsigned v_total = 0;
  int unsigned e_total = 0;
  int unsigned both_total = 0;
  logic [6:0]  cap_addr [8];
  logic [7:0]  cap_data [8];

  always #5 clk = ~clk;

  spi_frame_rx #(.NUM_REGS(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .copi        (copi),
    .ncs         (ncs),
    .frame_valid (frame_valid),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        cap_addr[v_total % 8] = frame_addr;
        cap_data[v_total % 8] = frame_data;
        v_total = v_total + 1;
      end
      if (frame_err) e_total = e_total + 1;
      if (frame_valid && frame_err) both_total = both_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    copi = b;
    clks(4);
    sclk = 1'b1;
    clks(4);
    sclk = 1'b0;
  endtask

  // Sends the low nbits of val MSB first, then raises nCS (no trailing wait).
  task automatic send_frame(input logic [31:0] val, input int unsigned nbits);
    ncs = 1'b0;
    clks(4);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int unsigned i = 0; i < nbits; i++) begin
      shift_bit(val[nbits-1-i]);
    end
    clks(4);
    ncs = 1'b1;
  endtask

  initial begin
    int unsigned v0, e0;

    clks(3);
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_err",   {31'd0, frame_err},   32'd0);
    chk("rst_addr",  {25'd0, frame_addr},  32'd0);
    chk("rst_data",  {24'd0, frame_data},  32'd0);
    chk("rst_busy",  {31'd0, busy},        32'd0);
    rst = 1'b0;
    clks(10);

    // Legal write
    v0 = v_total; e0 = e_total;
    send_frame(32'h80A5, 16);
    clks(10);
    chk("wr_valid_cnt", v_total - v0, 32'd1);
    chk("wr_err_cnt",   e_total - e0, 32'd0);
    chk("wr_addr",      {25'd0, frame_addr}, 32'h00);
    chk("wr_data",      {24'd0, frame_data}, 32'hA5);
    chk("idle_busy",    {31'd0, busy}, 32'd0);

    // Read frame dropped
    v0 = v_total; e0 = e_total;
    send_frame(32'h0433, 16);
    clks(10);
    chk("rd_valid_cnt", v_total - v0, 32'd0);
    chk("rd_err_cnt",   e_total - e0, 32'd0);
    chk("rd_addr_hold", {25'd0, frame_addr}, 32'h00);
    chk("rd_data_hold", {24'd0, frame_data}, 32'hA5);

    // Unmapped address
    v0 = v_total; e0 = e_total;
    send_frame(32'h90FF, 16);
    clks(10);
    chk("badaddr_err_cnt",   e_total - e0, 32'd1);
    chk("badaddr_valid_cnt", v_total - v0, 32'd0);
    chk("badaddr_data_hold", {24'd0, frame_data}, 32'hA5);

    // Boundary: highest legal address 4
    v0 = v_total; e0 = e_total;
    send_frame(32'h847E, 16);
    clks(10);
    chk("addr4_valid_cnt", v_total - v0, 32'd1);
    chk("addr4_err_cnt",   e_total - e0, 32'd0);
    chk("addr4_addr",      {25'd0, frame_addr}, 32'h04);
    chk("addr4_data",      {24'd0, frame_data}, 32'h7E);

    // Boundary: first illegal address 5
    v0 = v_total; e0 = e_total;
    send_frame(32'h8511, 16);
    clks(10);
    chk("addr5_err_cnt",   e_total - e0, 32'd1);
    chk("addr5_valid_cnt", v_total - v0, 32'd0);

    // Short frame (15 bits)
    v0 = v_total; e0 = e_total;
    send_frame(32'h40A5, 15);
    clks(10);
    chk("short_err_cnt",   e_total - e0, 32'd1);
    chk("short_valid_cnt", v_total - v0, 32'd0);

    // Overlength frame: 0x8204 followed by 4 extra bits
    v0 = v_total; e0 = e_total;
    send_frame(32'h82040, 20);
    clks(10);
    chk("long_err_cnt",   e_total - e0, 32'd1);
    chk("long_valid_cnt", v_total - v0, 32'd0);

    // Reset mid-frame, then complete the frame with nCS still low
    v0 = v_total; e0 = e_total;
    ncs = 1'b0;
    clks(4);
    for (int unsigned i = 0; i < 8; i++) shift_bit(i[0]);
    rst = 1'b1;
    clks(3);
    chk("midrst_data", {24'd0, frame_data}, 32'h00);
    rst = 1'b0;
    clks(6);
    for (int unsigned i = 0; i < 8; i++) shift_bit(1'b1);
    clks(4);
    ncs = 1'b1;
    clks(10);
    chk("midrst_valid_cnt", v_total - v0, 32'd0);
    chk("midrst_err_cnt",   e_total - e0, 32'd0);
    chk("midrst_addr",      {25'd0, frame_addr}, 32'h00);

    v0 = v_total; e0 = e_total;
    send_frame(32'h8412, 16);
    clks(10);
    chk("postrst_valid_cnt", v_total - v0, 32'd1);
    chk("postrst_addr",      {25'd0, frame_addr}, 32'h04);
    chk("postrst_data",      {24'd0, frame_data}, 32'h12);

    // Back-to-back writes, nCS high for 3 clk between them
    v0 = v_total; e0 = e_total;
    send_frame(32'h8101, 16);
    clks(3);
    send_frame(32'h8202, 16);
    clks(10);
    chk("b2b_valid_cnt", v_total - v0, 32'd2);
    chk("b2b_err_cnt",   e_total - e0, 32'd0);
    chk("b2b_addr0", {25'd0, cap_addr[v0 % 8]},       32'h01);
    chk("b2b_data0", {24'd0, cap_data[v0 % 8]},       32'h01);
    chk("b2b_addr1", {25'd0, cap_addr[(v0 + 1) % 8]}, 32'h02);
    chk("b2b_data1", {24'd0, cap_data[(v0 + 1) % 8]}, 32'h02);

    chk("valid_err_overlap", both_total, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
